// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: opcodes, cpu control codes, control-word struct and encoder for cpu_op_sequencer
package cpu_seq_pkg;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;
  localparam logic [1:0] OPSEL_ADD = 2'b00;
  localparam logic [1:0] OPSEL_SUB = 2'b01;
  localparam logic [1:0] OUTSEL_RF = 2'b00;
  localparam logic [1:0] OUTSEL_ALU = 2'b01;
  typedef struct packed {
    logic [1:0] op;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [31:0] data;
  } cmd_t;
  typedef struct packed {
    logic [4:0] addr_a;
    logic [4:0] addr_b;
    logic [31:0] data;
    logic [1:0] opsel;
    logic [1:0] outsel;
    logic asel;
    logic bsel;
    logic oen;
  } cw_t;
  localparam int CW_W = $bits(cw_t);
  // NOP is a READ of r0 with the output disabled
  localparam cw_t NOP_CW = '{addr_a: 5'd0, addr_b: 5'd0, data: 32'd0, opsel: OPSEL_SUB,
                             outsel: OUTSEL_RF, asel: 1'b1, bsel: 1'b0, oen: 1'b0};
  function automatic logic is_alu(logic [1:0] op);
    return op == OP_ADD || op == OP_SUB;
  endfunction
  function automatic cw_t encode(logic [1:0] op, logic [4:0] ra, logic [4:0] rb, logic [31:0] data);
    return '{addr_a: op == OP_LOAD ? 5'd0 : ra,
             addr_b: op == OP_READ ? ra : rb,
             data: op == OP_LOAD ? data : 32'd0,
             opsel: op == OP_ADD ? OPSEL_ADD : OPSEL_SUB,
             outsel: is_alu(op) ? OUTSEL_ALU : OUTSEL_RF,
             asel: op != OP_LOAD,
             bsel: is_alu(op),
             oen: 1'b1};
  endfunction
endpackage

// File: rtl/seq_fifo.sv
// seq_fifo: DEPTH-entry command FIFO; push ignored when full, pop ignored when empty
//   push/din in, pop in, dout = head entry, full/empty flags
module seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/cpu_op_sequencer.sv
// cpu_op_sequencer: issues queued LOAD/ADD/SUB/READ commands to the cpu datapath with RAW interlock
//   in_*: command handshake; addressA..oen: registered cpu control; outPut/over: cpu result
//   rsp_*: tagged result strobe; busy: work queued or in flight; stall_cnt: hazard bubbles
module cpu_op_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PIPE_LAT = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [4:0]       in_ra,
  input  logic [4:0]       in_rb,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic [4:0]       addressA,
  output logic [4:0]       addressB,
  output logic [31:0]      dataIn,
  output logic [1:0]       opsel,
  output logic [1:0]       outsel,
  output logic             asel,
  output logic             bsel,
  output logic             oen,
  input  logic [31:0]      outPut,
  input  logic             over,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             rsp_over,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [15:0]      stall_cnt
);
  cmd_t head;
  logic [TAG_W-1:0] head_tag;
  logic full, empty, hazard, go, stall;
  cw_t cw;
  // bit/index 0 is the command on the datapath this cycle, higher = issued earlier
  logic [PIPE_LAT-1:0] act, rv, rd;
  logic [TAG_W-1:0] tg [PIPE_LAT];
  // a write issued PIPE_LAT-1 or fewer cycles ago has not reached the register file yet
  logic [PIPE_LAT-2:0] wv;
  logic [4:0] dst [PIPE_LAT-1];
  seq_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t) + TAG_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(in_valid),
    .pop(go),
    .din({in_op, in_ra, in_rb, in_data, in_tag}),
    .dout({head, head_tag}),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++)
      hazard |= wv[i] && ((head.op != OP_LOAD && dst[i] == head.ra) ||
                          (is_alu(head.op) && dst[i] == head.rb));
  end
  assign go = !empty && !hazard;
  assign stall = !empty && hazard;
  assign in_ready = !full;
  assign busy = !empty || |act;
  assign addressA = cw.addr_a;
  assign addressB = cw.addr_b;
  assign dataIn = cw.data;
  assign opsel = cw.opsel;
  assign outsel = cw.outsel;
  assign asel = cw.asel;
  assign bsel = cw.bsel;
  assign oen = cw.oen;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cw <= NOP_CW;
      act <= '0;
      rv <= '0;
      rd <= '0;
      wv <= '0;
      for (int i = 0; i < PIPE_LAT; i++) tg[i] <= '0;
      for (int i = 0; i < PIPE_LAT - 1; i++) dst[i] <= '0;
      stall_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_over <= 1'b0;
      rsp_tag <= '0;
    end else begin
      cw <= go ? encode(head.op, head.ra, head.rb, head.data) : NOP_CW;
      act <= PIPE_LAT'({act, go});
      rv <= PIPE_LAT'({rv, go && head.op != OP_LOAD});
      rd <= PIPE_LAT'({rd, head.op == OP_READ});
      wv <= (PIPE_LAT-1)'({wv, go && head.op != OP_READ});
      for (int i = PIPE_LAT - 1; i > 0; i--) tg[i] <= tg[i-1];
      tg[0] <= head_tag;
      for (int i = PIPE_LAT - 2; i > 0; i--) dst[i] <= dst[i-1];
      dst[0] <= head.rb;
      stall_cnt <= stall && stall_cnt != 16'hFFFF ? stall_cnt + 16'd1 : stall_cnt;
      rsp_valid <= rv[PIPE_LAT-1];
      if (rv[PIPE_LAT-1]) begin
        rsp_data <= outPut;
        rsp_over <= over && !rd[PIPE_LAT-1];
        rsp_tag <= tg[PIPE_LAT-1];
      end
    end
endmodule

// File: tb/tb_cpu_op_sequencer.sv
// tb_cpu_op_sequencer: directed self-checking bench with a cpu datapath model and a program-order reference
module tb_cpu_op_sequencer;
  localparam int DEPTH = 4;
  localparam int PL = 2;
  localparam logic [1:0] LD = 2'b00, AD = 2'b01, SB = 2'b10, RD = 2'b11;
  logic clk, reset, in_valid, in_ready, asel, bsel, oen, over, rsp_valid, rsp_over, busy;
  logic [1:0] in_op, opsel, outsel;
  logic [4:0] in_ra, in_rb, addressA, addressB;
  logic [31:0] in_data, dataIn, outPut, rsp_data;
  logic [3:0] in_tag, rsp_tag;
  logic [15:0] stall_cnt;
  int n_chk = 0, n_pass = 0, n_rsp = 0, c = 0;
  logic saw_full = 0;
  logic [31:0] got [16];
  logic gov [16];

  cpu_op_sequencer #(.DEPTH(DEPTH), .PIPE_LAT(PL), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_ra(in_ra), .in_rb(in_rb), .in_data(in_data), .in_tag(in_tag),
    .addressA(addressA), .addressB(addressB), .dataIn(dataIn), .opsel(opsel), .outsel(outsel),
    .asel(asel), .bsel(bsel), .oen(oen), .outPut(outPut), .over(over),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_over(rsp_over), .rsp_tag(rsp_tag),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // cpu datapath: control latched one cycle, result on outPut in the next, written back at its end
  logic [31:0] rf [32];
  logic s_oen, s_alu, s_sub, s_ld;
  logic [4:0] s_a, s_b;
  logic [31:0] s_d, alu;
  logic alu_ov;
  always @(posedge clk) begin
    s_oen <= oen;
    s_alu <= outsel == 2'b01;
    s_sub <= opsel == 2'b01;
    s_ld <= !asel;
    s_a <= addressA;
    s_b <= addressB;
    s_d <= dataIn;
    if (s_oen && (s_alu || s_ld)) rf[s_b] <= s_alu ? alu : s_d;
  end
  assign alu = s_sub ? rf[s_a] - rf[s_b] : rf[s_a] + rf[s_b];
  assign alu_ov = s_sub ? (rf[s_a][31] != rf[s_b][31]) && (alu[31] != rf[s_a][31])
                        : (rf[s_a][31] == rf[s_b][31]) && (alu[31] != rf[s_a][31]);
  assign outPut = s_alu ? alu : s_ld ? s_d : rf[s_a];
  // overflow is meaningless outside ALU ops; hold it high so a READ must mask it
  assign over = s_alu ? alu_ov : 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
  endtask

  // inputs as seen by the DUT at the last rising edge
  logic c_v, c_rst;
  logic [1:0] c_op;
  logic [4:0] c_ra, c_rb;
  logic [31:0] c_d;
  logic [3:0] c_tag;
  always @(posedge clk) begin
    c_v <= in_valid;
    c_op <= in_op;
    c_ra <= in_ra;
    c_rb <= in_rb;
    c_d <= in_data;
    c_tag <= in_tag;
    c_rst <= reset;
  end

  // reference: program-order architectural state, issue allowed PL cycles after a source's producer
  typedef struct {logic [1:0] op; logic [4:0] ra, rb; logic [31:0] d; logic [3:0] tag;} cmd_s;
  typedef struct {int due; logic [31:0] d; logic o; logic [3:0] tag;} rsp_s;
  cmd_s q[$];
  rsp_s pend[$];
  logic [31:0] ar [32];
  int lastw [32];
  int last_issue, m_stall;
  initial begin
    cmd_s h;
    rsp_s rs;
    int sz0;
    logic ok, e_rv, chk_d;
    logic [4:0] e_a, e_b;
    logic [1:0] e_os, e_ou;
    logic e_as, e_bs, e_oe, ov;
    logic [31:0] e_d, a, b, r;
    forever begin
      @(negedge clk);
      #1;
      c++;
      if (reset || c_rst) begin
        q.delete();
        pend.delete();
        for (int i = 0; i < 32; i++) lastw[i] = -100;
        last_issue = -100;
        m_stall = 0;
      end else begin
        {e_a, e_b, e_d, e_os, e_ou, e_as, e_bs, e_oe, chk_d} = {5'd0, 5'd0, 32'd0, 2'b01, 2'b00, 3'b100, 1'b1};
        sz0 = q.size();
        if (sz0 > 0) begin
          h = q[0];
          ok = !(h.op != LD && c - lastw[h.ra] < PL) && !((h.op == AD || h.op == SB) && c - lastw[h.rb] < PL);
          if (ok) begin
            void'(q.pop_front());
            last_issue = c;
            e_oe = 1;
            if (h.op == LD) begin
              {e_b, e_d, e_as} = {h.rb, h.d, 1'b0};
              ar[h.rb] = h.d;
              lastw[h.rb] = c;
            end else if (h.op == RD) begin
              {e_a, e_b, chk_d} = {h.ra, h.ra, 1'b0};
              pend.push_back('{c + PL, ar[h.ra], 1'b0, h.tag});
            end else begin
              {e_a, e_b, e_ou, e_bs, chk_d} = {h.ra, h.rb, 2'b01, 1'b1, 1'b0};
              e_os = h.op == SB ? 2'b01 : 2'b00;
              a = ar[h.ra];
              b = ar[h.rb];
              r = h.op == SB ? a - b : a + b;
              ov = (h.op == SB ? a[31] != b[31] : a[31] == b[31]) && r[31] != a[31];
              ar[h.rb] = r;
              lastw[h.rb] = c;
              pend.push_back('{c + PL, r, ov, h.tag});
            end
          end else if (m_stall < 65535) m_stall++;
        end
        if (c_v && sz0 < DEPTH) q.push_back('{c_op, c_ra, c_rb, c_d, c_tag});
        e_rv = pend.size() > 0 && pend[0].due == c;
        chk("ctrl", {addressA, addressB, opsel, outsel, asel, bsel, oen}, {e_a, e_b, e_os, e_ou, e_as, e_bs, e_oe});
        if (chk_d) chk("dataIn", dataIn, e_d);
        chk("rsp_valid", rsp_valid, e_rv);
        if (e_rv) begin
          rs = pend.pop_front();
          chk("rsp_data", rsp_data, rs.d);
          chk("rsp_over", rsp_over, rs.o);
          chk("rsp_tag", rsp_tag, rs.tag);
        end
        chk("busy", busy, q.size() > 0 || c - last_issue < PL);
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("stall_cnt", stall_cnt, m_stall);
      end
      if (!reset && rsp_valid) begin
        n_rsp++;
        got[rsp_tag] = rsp_data;
        gov[rsp_tag] = rsp_over;
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [4:0] ra, input logic [4:0] rb,
                      input logic [31:0] d, input logic [3:0] tag);
    int k = 0;
    {in_valid, in_op, in_ra, in_rb, in_data, in_tag} = {1'b1, op, ra, rb, d, tag};
    while (!in_ready && k < 100) begin
      saw_full = 1;
      @(negedge clk);
      k++;
    end
    if (k == 100) chk("push_timeout", 1, 0);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain;
    int k = 0;
    @(negedge clk);
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k == 300) chk("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n0;
    {reset, in_valid, in_op, in_ra, in_rb, in_data, in_tag} = '0;
    reset = 1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_oen", oen, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_stall", stall_cnt, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    push(LD, 0, 0, 32'hFFFFFFEA, 0);
    push(LD, 0, 1, 32'h0000000C, 0);
    push(LD, 0, 2, 32'h00000020, 0);
    push(LD, 0, 20, 32'h00000034, 0);
    drain();
    chk("p1_no_rsp", n_rsp, 0);
    chk("p1_stall", stall_cnt, 0);
    push(AD, 0, 1, 0, 1);
    push(AD, 1, 2, 0, 2);
    drain();
    chk("p2_add1", {gov[1], got[1]}, {1'b0, 32'hFFFFFFF6});
    chk("p2_add2", {gov[2], got[2]}, {1'b0, 32'h00000016});
    chk("p2_stall", stall_cnt, 1);
    push(SB, 0, 20, 0, 3);
    push(RD, 1, 0, 0, 4);
    push(RD, 2, 0, 0, 5);
    push(RD, 20, 0, 0, 6);
    drain();
    chk("p3_sub", got[3], 32'hFFFFFFB6);
    chk("p3_rd1", {gov[4], got[4]}, {1'b0, 32'hFFFFFFF6});
    chk("p3_rd2", {gov[5], got[5]}, {1'b0, 32'h00000016});
    chk("p3_rd20", {gov[6], got[6]}, {1'b0, 32'hFFFFFFB6});
    chk("p3_stall", stall_cnt, 1);
    push(LD, 0, 3, 32'h7FFFFFFF, 0);
    push(LD, 0, 4, 32'h00000001, 0);
    push(AD, 3, 4, 0, 7);
    drain();
    chk("p4_ovf", {gov[7], got[7]}, {1'b1, 32'h80000000});
    chk("p4_stall", stall_cnt, 2);
    saw_full = 0;
    push(LD, 0, 5, 32'h1, 0);
    for (int i = 0; i < 8; i++) push(AD, 5, 5, 0, 4'(8 + i));
    drain();
    chk("p5_full_seen", saw_full, 1);
    for (int i = 0; i < 8; i++) chk("p5_chain", got[8 + i], 32'd2 << i);
    chk("p5_rsp_count", n_rsp, 15);
    chk("p5_stall", stall_cnt, 10);
    n0 = n_rsp;
    push(AD, 0, 1, 0, 9);
    #2;
    chk("p6_not_yet", oen, 0);
    @(negedge clk);
    #2;
    chk("p6_issued", oen, 1);
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);
    #2;
    chk("p6_no_rsp", n_rsp, n0);
    chk("p6_oen", oen, 0);
    chk("p6_busy", busy, 0);
    chk("p6_stall", stall_cnt, 0);
    chk("p6_in_ready", in_ready, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
